// File: rtl/sca_trigger_ctrl_pkg.sv
// Shared types and default constants for the side-channel capture trigger sequencer.
package sca_trigger_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StDelay  = 3'd2,
        StActive = 3'd3,
        StDone   = 3'd4
    } sca_trig_state_e;

    typedef enum logic {
        ModeGate  = 1'b0,
        ModePulse = 1'b1
    } sca_trig_mode_e;

    localparam int unsigned DefDelayW        = 8;
    localparam int unsigned DefWidthW        = 8;
    localparam int unsigned DefCntW          = 16;
    localparam int unsigned DefTimeoutCycles = 65535;

endpackage

// File: rtl/sca_trigger_timer.sv
// Loadable down-counter that stops at zero; zero_o flags an expired count.
module sca_trigger_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (load_i) begin
            count <= load_val_i;
        end else if (en_i && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero_o = (count == '0);

endmodule

// File: rtl/sca_trigger_ctrl.sv
// Capture trigger sequencer: qualifies a GPIO request with datapath busy, then delays and shapes trig_o.
// Optional Armed-state timeout is compiled in with SCA_TRIGGER_CTRL_TIMEOUT_EN.
module sca_trigger_ctrl
    import sca_trigger_ctrl_pkg::*;
#(
    parameter int unsigned DelayW        = DefDelayW,
    parameter int unsigned WidthW        = DefWidthW,
    parameter int unsigned CntW          = DefCntW,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              sw_trig_i,
    input  logic              busy_i,
    input  logic [DelayW-1:0] delay_i,
    input  logic [WidthW-1:0] width_i,
    input  logic              mode_i,
    input  logic              cnt_clr_i,
    output logic              trig_o,
    output logic              armed_o,
    output logic [CntW-1:0]   trig_cnt_o,
    output logic              timeout_o,
    output sca_trig_state_e   state_o
);

    localparam int unsigned TimerW = (DelayW > WidthW) ? DelayW : WidthW;

    sca_trig_state_e state_q, state_d;
    sca_trig_mode_e  mode;
    logic            sw_trig_q;
    logic            sw_rise;
    logic            tmr_load;
    logic            tmr_en;
    logic            tmr_zero;
    logic [TimerW-1:0] tmr_val;
    logic [TimerW-1:0] delay_ld;
    logic [TimerW-1:0] width_ld;
    logic            cnt_inc;
    logic            trig_q;
    logic            armed_q;
    logic [CntW-1:0] cnt_q;

    assign mode     = sca_trig_mode_e'(mode_i);
    assign sw_rise  = sw_trig_i & ~sw_trig_q;
    assign delay_ld = TimerW'(delay_i - 1'b1);
    // A zero width still produces a one-cycle pulse.
    assign width_ld = (width_i == '0) ? '0 : TimerW'(width_i - 1'b1);
    assign tmr_en   = (state_q == StDelay) || (state_q == StActive);

`ifdef SCA_TRIGGER_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

    logic tmo_load;
    logic tmo_zero;
    logic tmo_set;
    logic timeout_q;

    sca_trigger_timer #(.W(TmoW)) u_tmo_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmo_load),
        .en_i       (state_q == StArmed),
        .load_val_i (TmoW'(TimeoutCycles - 1)),
        .zero_o     (tmo_zero)
    );
`endif

    sca_trigger_timer #(.W(TimerW)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef SCA_TRIGGER_CTRL_TIMEOUT_EN
        tmo_load = 1'b0;
        tmo_set  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (en_i && sw_rise) begin
                    state_d = StArmed;
`ifdef SCA_TRIGGER_CTRL_TIMEOUT_EN
                    tmo_load = 1'b1;
`endif
                end
            end
            StArmed: begin
                if (!sw_trig_i) begin
                    state_d = StIdle;
                end else if (busy_i) begin
                    tmr_load = 1'b1;
                    if (delay_i == '0) begin
                        state_d = StActive;
                        tmr_val = width_ld;
                    end else begin
                        state_d = StDelay;
                        tmr_val = delay_ld;
                    end
`ifdef SCA_TRIGGER_CTRL_TIMEOUT_EN
                end else if (tmo_zero) begin
                    state_d = StDone;
                    tmo_set = 1'b1;
`endif
                end
            end
            StDelay: begin
                if ((mode == ModeGate) && !busy_i) begin
                    state_d = StDone;
                end else if (tmr_zero) begin
                    state_d  = StActive;
                    tmr_load = 1'b1;
                    tmr_val  = width_ld;
                end
            end
            StActive: begin
                if (mode == ModePulse) begin
                    if (tmr_zero) begin
                        state_d = StDone;
                    end
                end else if (!busy_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!sw_trig_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Disable takes priority over every transition above, so an aborted Active never counts.
        if (!en_i) begin
            state_d = StIdle;
        end
    end

    assign cnt_inc = (state_q == StActive) && (state_d == StDone);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            sw_trig_q <= 1'b0;
            trig_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_trig_q <= sw_trig_i;
            trig_q    <= (state_d == StActive);
            armed_q   <= (state_d == StArmed);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef SCA_TRIGGER_CTRL_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (tmo_load && en_i) begin
            timeout_q <= 1'b0;
        end else if (tmo_set && en_i) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign trig_o     = trig_q;
    assign armed_o    = armed_q;
    assign trig_cnt_o = cnt_q;
    assign state_o    = state_q;

endmodule
